param_sp_ram: RTL

//  Parametrised single-port synchronous RAM; next generation of the 16x8 bidirectional-bus RAM.

---
 rtl/param_sp_ram.sv | 133 +++++++++++++
 1 files changed

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset clear sweep.
module param_sp_ram #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                RD_LAT   = 1,
    parameter int                WR_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                init_busy,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                dbg_state_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign ready       = (state_q == ST_RUN);
    assign init_busy   = (state_q == ST_INIT);
    assign dbg_state_o = (state_q == ST_RUN);

    // Handshake: a request transfers on a rising edge where req && ready; there is no
    // back-pressure on the response side, rvalid is a single-cycle strobe.
    assign acc      = req && ready;
    assign old_word = mem[addr];

    always_comb begin
        merged = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    assign resp_valid = acc && (!we || (WR_MODE != 2));
    assign resp_data  = (we && (WR_MODE == 1)) ? merged : old_word;

    // rst_n gates the array write so an edge seen while reset is held does nothing.
    assign mem_we    = rst_n && (init_busy || (acc && we));
    assign mem_waddr = init_busy ? sweep_q : addr;
    assign mem_wdata = init_busy ? INIT_VAL : merged;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid_q;
            logic [DATA_W-1:0] s1_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= resp_valid;
                    if (resp_valid) s1_data_q <= resp_data;
                end
            end

            assign out_valid = s1_valid_q;
            assign out_data  = s1_data_q;
        end else begin : g_lat1
            assign out_valid = resp_valid;
            assign out_data  = resp_data;
        end
    endgenerate

    // rdata only moves together with an rvalid strobe, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= out_valid;
            if (out_valid) rdata_q <= out_data;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
